risc16_fetch: RTL and testbench

- Instruction-fetch stage directly downstream of program_counter: takes the current pc, issues one instruction-memory read, and holds the returned word in an IF/ID register for decode.
- Generates the pc-advance enable for program_counter and discards wrong-path fetches when execute redirects the pc (branch/jalr taken).
- Variable-latency memory via valid/ready handshake; at most one outstanding request.

---
 rtl/risc16_pkg.sv | 15 +
 rtl/risc16_fetch.sv | 123 ++++++++++++
 tb/tb_risc16_fetch.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/risc16_pkg.sv
// Shared definitions for the RISC-16 front end: datapath width, NOP encoding
// and the fetch FSM state type.
package risc16_pkg;

  localparam int XLEN = 16;

  // add r0,r0,r0
  localparam logic [15:0] NOP = 16'h0000;

  typedef enum logic {
    REQ  = 1'b0,
    WAIT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/risc16_fetch.sv
// Instruction fetch stage: one outstanding imem read, IF/ID holding register,
// pc-advance generation and wrong-path squash on execute redirects.
module risc16_fetch #(
  parameter int              XLEN      = risc16_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_NOP = risc16_pkg::NOP
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  output logic            pc_advance,
  input  logic            redirect,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            ifid_valid,
  input  logic            ifid_ready,
  output logic [XLEN-1:0] ifid_instr,
  output logic [XLEN-1:0] ifid_pc
);

  import risc16_pkg::*;

  fetch_state_e    state_r, state_n_s;
  logic            drop_r, drop_n_s;
  logic [XLEN-1:0] req_pc_r, req_pc_n_s;
  logic            ifid_valid_r, ifid_valid_n_s;
  logic [XLEN-1:0] ifid_instr_r, ifid_instr_n_s;
  logic [XLEN-1:0] ifid_pc_r, ifid_pc_n_s;
  logic            req_valid_s;
  logic            accept_s;
  logic            load_s;

  // Next-state logic for the fetch FSM and the IF/ID register.
  always_comb begin
    state_n_s      = state_r;
    drop_n_s       = drop_r;
    req_pc_n_s     = req_pc_r;
    ifid_valid_n_s = ifid_valid_r;
    ifid_instr_n_s = ifid_instr_r;
    ifid_pc_n_s    = ifid_pc_r;
    req_valid_s    = 1'b0;
    accept_s       = 1'b0;
    load_s         = 1'b0;

    case (state_r)
      REQ: begin
        // Only request when IF/ID will have room for the answer.
        req_valid_s = !redirect && (!ifid_valid_r || ifid_ready);
        accept_s    = req_valid_s && imem_req_ready;
        if (accept_s) begin
          state_n_s  = WAIT;
          req_pc_n_s = pc;
          drop_n_s   = 1'b0;
        end else begin
          state_n_s  = REQ;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          state_n_s = REQ;
          drop_n_s  = 1'b0;
          load_s    = !drop_r && !redirect;
        end else if (redirect) begin
          drop_n_s  = 1'b1;
        end else begin
          drop_n_s  = drop_r;
        end
      end
      default: begin
        state_n_s = REQ;
        drop_n_s  = 1'b0;
      end
    endcase

    if (redirect) begin
      ifid_valid_n_s = 1'b0;
    end else if (load_s) begin
      ifid_valid_n_s = 1'b1;
      ifid_instr_n_s = imem_rsp_data;
      ifid_pc_n_s    = req_pc_r;
    end else if (ifid_valid_r && ifid_ready) begin
      ifid_valid_n_s = 1'b0;
    end else begin
      ifid_valid_n_s = ifid_valid_r;
    end

    // An empty IF/ID always presents the NOP to decode.
    if (!ifid_valid_n_s) begin
      ifid_instr_n_s = RESET_NOP;
    end else begin
      ifid_instr_n_s = ifid_instr_n_s;
    end
  end

  // State and IF/ID registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= REQ;
      drop_r       <= 1'b0;
      req_pc_r     <= '0;
      ifid_valid_r <= 1'b0;
      ifid_instr_r <= RESET_NOP;
      ifid_pc_r    <= '0;
    end else begin
      state_r      <= state_n_s;
      drop_r       <= drop_n_s;
      req_pc_r     <= req_pc_n_s;
      ifid_valid_r <= ifid_valid_n_s;
      ifid_instr_r <= ifid_instr_n_s;
      ifid_pc_r    <= ifid_pc_n_s;
    end
  end

  assign pc_advance     = accept_s;
  assign imem_req_valid = req_valid_s;
  assign imem_addr      = pc;
  assign ifid_valid     = ifid_valid_r;
  assign ifid_instr     = ifid_instr_r;
  assign ifid_pc        = ifid_pc_r;

endmodule

// File: tb/tb_risc16_fetch.sv
// Directed bench for risc16_fetch with a transaction-level fetch model and a
// latency-programmable instruction memory.
module tb_risc16_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic        pc_advance;
  logic        redirect;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [15:0] imem_addr;
  logic        imem_rsp_valid;
  logic [15:0] imem_rsp_data;
  logic        ifid_valid;
  logic        ifid_ready;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc;

  risc16_fetch dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_advance(pc_advance),
    .redirect(redirect), .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .ifid_valid(ifid_valid), .ifid_ready(ifid_ready),
    .ifid_instr(ifid_instr), .ifid_pc(ifid_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Instruction memory contents.
  function automatic logic [15:0] memf(input logic [15:0] a);
    if (a == 16'd8) return 16'hBEEF;
    return {a[7:0] ^ 8'h5A, a[7:0]};
  endfunction

  // Transaction-level model: an outstanding read (maybe killed) and a held instruction.
  logic        m_out = 1'b0, m_kill = 1'b0, m_held = 1'b0;
  logic [15:0] m_rpc = 16'h0000, m_instr = 16'h0000, m_ipc = 16'h0000;

  always @(negedge clk) begin
    logic er, ea, resp, keep;
    if (!reset) begin
      m_out = 1'b0; m_kill = 1'b0; m_held = 1'b0;
      m_rpc = 16'h0000; m_instr = 16'h0000; m_ipc = 16'h0000;
    end
    er = !m_out && !redirect && (!m_held || ifid_ready);
    ea = er && imem_req_ready;
    chk("req_valid", {15'd0, imem_req_valid}, {15'd0, er});
    chk("pc_advance", {15'd0, pc_advance}, {15'd0, ea});
    if (er) chk("imem_addr", imem_addr, pc);
    chk("ifid_valid", {15'd0, ifid_valid}, {15'd0, m_held});
    chk("ifid_instr", ifid_instr, m_instr);
    chk("ifid_pc", ifid_pc, m_ipc);
    if (reset) begin
      resp = m_out && imem_rsp_valid;
      keep = resp && !m_kill && !redirect;
      if (redirect) begin
        m_held = 1'b0; m_instr = 16'h0000;
      end else if (keep) begin
        m_held = 1'b1; m_instr = imem_rsp_data; m_ipc = m_rpc;
      end else if (m_held && ifid_ready) begin
        m_held = 1'b0; m_instr = 16'h0000;
      end
      if (resp) begin
        m_out = 1'b0; m_kill = 1'b0;
      end else if (redirect && m_out) begin
        m_kill = 1'b1;
      end
      if (ea) begin
        m_out = 1'b1; m_kill = 1'b0; m_rpc = pc;
      end
    end
  end

  // Memory and upstream pc emulation, advanced one clock per tick.
  int          cyc = 0, adv_count = 0, mem_lat = 1, mem_cnt = 0;
  int          adv_cyc[$];
  logic [15:0] acc_log[$];
  logic        mem_busy = 1'b0, auto_pc = 1'b0, adv_now = 1'b0;
  logic [15:0] mem_q = 16'h0000, acc_addr_now = 16'hFFFF;

  task automatic tick();
    logic acc, rs;
    logic [15:0] a;
    @(negedge clk);
    rs      = reset;
    acc     = imem_req_valid && imem_req_ready && reset;
    a       = imem_addr;
    adv_now = pc_advance && reset;
    @(posedge clk);
    #1;
    cyc++;
    imem_rsp_valid = 1'b0;
    if (!rs) begin
      mem_busy = 1'b0;
    end else begin
      if (adv_now) begin
        adv_count++;
        adv_cyc.push_back(cyc);
      end
      if (acc) begin
        mem_busy = 1'b1; mem_cnt = mem_lat; mem_q = a;
        acc_log.push_back(a); acc_addr_now = a;
      end
      if (mem_busy) begin
        if (mem_cnt <= 1) begin
          imem_rsp_valid = 1'b1; imem_rsp_data = memf(mem_q); mem_busy = 1'b0;
        end else begin
          mem_cnt--;
        end
      end
      if (auto_pc && acc) pc = pc + 16'd1;
    end
  endtask

  initial begin
    int c0;
    reset = 1'b0; pc = 16'h0000; redirect = 1'b0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = 16'h0000; ifid_ready = 1'b1;

    // Reset state
    repeat (2) tick();
    chk("rst_valid", {15'd0, ifid_valid}, 16'd0);
    chk("rst_instr", ifid_instr, 16'h0000);
    chk("rst_pc", ifid_pc, 16'h0000);

    // Zero-wait streaming of pc 0..3
    reset = 1'b1; imem_req_ready = 1'b1; mem_lat = 1; auto_pc = 1'b1;
    for (int i = 0; i < 40 && adv_count < 4; i++) tick();
    auto_pc = 1'b0;
    chk("t1_adv_count", adv_count[15:0], 16'd4);
    tick();
    chk("t1_last_pc", ifid_pc, 16'd3);
    chk("t1_last_instr", ifid_instr, 16'h5903);
    chk("t1_rate", (adv_cyc.size() >= 4) ? 16'(adv_cyc[3] - adv_cyc[0]) : 16'hFFFF, 16'd6);
    for (int i = 0; i < 4; i++)
      chk("t1_order", (acc_log.size() > i) ? acc_log[i] : 16'hFFFF, 16'(i));

    // Decode stall with IF/ID full at pc=5
    pc = 16'd5;
    repeat (6) tick();
    ifid_ready = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_req_valid", {15'd0, imem_req_valid}, 16'd0);
      chk("t2_adv", {15'd0, pc_advance}, 16'd0);
      chk("t2_pc", ifid_pc, 16'd5);
      chk("t2_instr", ifid_instr, 16'h5F05);
    end
    ifid_ready = 1'b1;
    c0 = adv_count;
    tick();
    chk("t2_resume", adv_count[15:0], 16'(c0 + 1));

    // Redirect while the pc=8 read is in flight
    mem_lat = 3; pc = 16'd8;
    for (int i = 0; i < 12 && !(adv_now && acc_addr_now == 16'd8); i++) tick();
    chk("t3_req8", {15'd0, adv_now && acc_addr_now == 16'd8}, 16'd1);
    redirect = 1'b1; pc = 16'd20; acc_log.delete();
    tick();
    redirect = 1'b0;
    chk("t3_flush", {15'd0, ifid_valid}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_drop", {15'd0, ifid_valid}, 16'd0);
    end
    for (int i = 0; i < 10 && acc_log.size() == 0; i++) tick();
    chk("t3_next_addr", (acc_log.size() > 0) ? acc_log[0] : 16'hFFFF, 16'd20);
    for (int i = 0; i < 10 && !ifid_valid; i++) tick();
    chk("t3_load_pc", ifid_pc, 16'd20);
    chk("t3_load_instr", ifid_instr, 16'h4E14);

    // Redirect in the same cycle as the response
    mem_lat = 2; pc = 16'd30;
    for (int i = 0; i < 12 && !(adv_now && acc_addr_now == 16'd30); i++) tick();
    chk("t4_req30", {15'd0, adv_now && acc_addr_now == 16'd30}, 16'd1);
    for (int i = 0; i < 6 && !imem_rsp_valid; i++) tick();
    chk("t4_rsp_seen", {15'd0, imem_rsp_valid}, 16'd1);
    redirect = 1'b1; pc = 16'd31;
    tick();
    redirect = 1'b0;
    chk("t4_flush", {15'd0, ifid_valid}, 16'd0);
    for (int i = 0; i < 10 && !ifid_valid; i++) tick();
    chk("t4_load_pc", ifid_pc, 16'd31);
    chk("t4_load_instr", ifid_instr, 16'h451F);

    // Memory back-pressure at pc=3
    mem_lat = 1; imem_req_ready = 1'b0; pc = 16'd3;
    repeat (4) tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_req_valid", {15'd0, imem_req_valid}, 16'd1);
      chk("t5_addr", imem_addr, 16'd3);
      chk("t5_adv", {15'd0, pc_advance}, 16'd0);
    end
    imem_req_ready = 1'b1;
    c0 = adv_count;
    tick();
    chk("t5_one_adv", adv_count[15:0], 16'(c0 + 1));
    chk("t5_adv_low", {15'd0, pc_advance}, 16'd0);

    // Reset during WAIT followed by a stray response
    mem_lat = 5; pc = 16'd40;
    for (int i = 0; i < 12 && !(adv_now && acc_addr_now == 16'd40); i++) tick();
    chk("t6_req40", {15'd0, adv_now && acc_addr_now == 16'd40}, 16'd1);
    reset = 1'b0;
    #1;
    chk("t6_rst_valid", {15'd0, ifid_valid}, 16'd0);
    chk("t6_rst_instr", ifid_instr, 16'h0000);
    chk("t6_rst_pc", ifid_pc, 16'h0000);
    tick();
    imem_req_ready = 1'b0; reset = 1'b1;
    imem_rsp_valid = 1'b1; imem_rsp_data = 16'h1234;
    #1;
    chk("t6_state_req", {15'd0, imem_req_valid}, 16'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_stray_valid", {15'd0, ifid_valid}, 16'd0);
      chk("t6_stray_instr", ifid_instr, 16'h0000);
      chk("t6_still_req", {15'd0, imem_req_valid}, 16'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
